piradip_ram_arbiter: RTL and testbench
======================================

Name: piradip_ram_arbiter

Overview:
- Round-robin arbiter that shares one port of piradip_tdp_ram (CLIENT side of piradip_ram_if) between NUM_CLIENTS requesters.
- Issues at most one RAM access per cycle.
- Tracks the RAM read latency and routes each read word back to the requester that issued it.
- Sits between DMA/control engines and one side of a dual-port buffer; the other port is served independently.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..16)
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 10, RAM word-address width
- READ_LATENCY, 1, RAM read latency in cycles (1..4); must equal the RAM port's READ_LATENCY setting

Ports:
- clk  input  1  single clock for arbiter and RAM port
- rstn  input  1  asynchronous active-low reset
- req_valid  input  NUM_CLIENTS  per-client request valid
- req_ready  output  NUM_CLIENTS  per-client grant/accept; a transfer occurs when valid&ready
- req_we  input  NUM_CLIENTS  1 = write, 0 = read
- req_addr  input  NUM_CLIENTS*ADDR_WIDTH  packed per-client address, client i at slice i
- req_wdata  input  NUM_CLIENTS*DATA_WIDTH  packed per-client write data
- rsp_valid  output  NUM_CLIENTS  one-cycle pulse: read data for client i is on rsp_rdata
- rsp_rdata  output  DATA_WIDTH  read data, shared by all clients
- ram_en  output  1  RAM enable
- ram_we  output  1  RAM write enable
- ram_addr  output  ADDR_WIDTH  RAM address
- ram_wdata  output  DATA_WIDTH  RAM write data
- ram_rdata  input  DATA_WIDTH  RAM read data

Behaviour:
- Clock and reset: one clock `clk`; reset `rstn` is asynchronous and active-low.
- Reset values: rr_ptr=0; latency pipeline cleared; rsp_valid=0; state=ARB.
- Grant (combinational, same cycle):
  - Winner is the first client with req_valid set, searching from rr_ptr upward with wrap from NUM_CLIENTS-1 to 0.
  - req_ready is one-hot on the winner; all-zero if no client is valid.
  - ram_en=|req_valid. ram_we, ram_addr and ram_wdata are muxed from the winner; they are 0 when idle.
- Round-robin pointer: on any accepted transfer, rr_ptr <= winner+1 mod NUM_CLIENTS. With no transfer, rr_ptr holds.
- Fairness: a continuously requesting client waits at most NUM_CLIENTS-1 cycles for a grant.
- Handshake:
  - req_ready may depend on req_valid.
  - A client must hold valid, we, addr and wdata stable until ready is seen.
  - No combinational path from req_ready back to req_valid is permitted in clients.
- Writes: complete at acceptance; no response is generated.
- Reads:
  - A READ_LATENCY-deep shift register carries {valid, client_id}; it is loaded on an accepted read.
  - rsp_valid[id] pulses exactly READ_LATENCY cycles after acceptance.
  - rsp_rdata = ram_rdata in that cycle; rsp_rdata is don't-care when no rsp_valid is set.
  - Responses have no backpressure. Back-to-back reads give back-to-back responses in issue order.
- Throughput: 1 access/cycle sustained; read/write interleaving has no bubbles.
- Same-address write then read from different clients: the read observes the RAM's write-mode semantics; the arbiter adds no forwarding.
- Reset mid-operation: in-flight read responses are discarded (no rsp_valid after reset). The RAM port is not reset by this block.
- States: ARB (normal round-robin); LOCKED exists only with the optional feature.

Optional Feature:
- Macro: PIRADIP_RAM_ARB_LOCK_EN.
- When defined:
  - Adds input req_lock [NUM_CLIENTS].
  - An accepted transfer with req_lock[i]=1 moves ARB->LOCKED with owner=i. In LOCKED only the owner can be granted; other clients stall.
  - The owner's accepted transfer with req_lock=0 returns to ARB, and rr_ptr <= owner+1.
  - Owner deasserting req_valid does not release the lock.
  - Reset forces ARB.
- When undefined: the port is absent and the block stays permanently in ARB.

Decomposition:
- Package piradip_ram_arb_pkg holds:
  - arb_state_t enum {ARB, LOCKED}
  - a clog2-based client-id width function
  - a pipeline entry struct {valid, id}
- One natural sub-module: piradip_rr_select (combinational: request vector + pointer -> one-hot grant and index), reusable by other arbiters.

Test Plan:
- Single client 2 writes 0x10<=0xA5A5, then read 0x10, READ_LATENCY=2 -> rsp_valid[2] exactly 2 cycles after read accept, rsp_rdata=0xA5A5, no other rsp_valid bits.
- All 4 clients valid continuously for 16 cycles from reset -> grant order 0,1,2,3,0,1,...; each client gets exactly 4 grants.
- Clients 1 and 3 issue back-to-back reads of addresses 5 and 9 (preloaded 0x55, 0x99) -> rsp_valid[1] with 0x55 then rsp_valid[3] with 0x99 on consecutive cycles.
- rstn asserted 1 cycle after a read is accepted with READ_LATENCY=3 -> no rsp_valid pulse afterward; rr_ptr=0; first post-reset grant goes to the lowest valid client.
- LOCK_EN: client 0 issues 3 locked writes and then an unlocked one while client 1 requests throughout -> client 1 first granted on the cycle after client 0's unlocked transfer.
- Idle (all req_valid=0) -> ram_en=0, req_ready=0, rr_ptr unchanged.

Source files
------------

// File: rtl/piradip_ram_arb_pkg.sv
// Shared types and helpers for the piradip RAM arbiter family.
package piradip_ram_arb_pkg;

  // Widest client id carried in the read-return pipeline (up to 16 clients).
  localparam int unsigned MAX_ID_W = 4;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Bits needed to index n clients; never less than one.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : 32'($clog2(n));
  endfunction

  // One stage of the read-return pipeline.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } pipe_entry_t;

endpackage

// File: rtl/piradip_rr_select.sv
// Round-robin selector: first set request at or after ptr, wrapping at N-1.
module piradip_rr_select #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  localparam int unsigned CW = IDW + 1;

  logic [CW-1:0] cand;
  logic          found;

  // Scan candidates ptr, ptr+1, ... modulo N; keep the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand = CW'(ptr) + CW'(k);
      if (cand >= CW'(N)) cand = cand - CW'(N);
      if (!found && req[cand[IDW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDW-1:0];
      end
    end
    if (found) grant[idx] = 1'b1;
    any = found;
  end

endmodule

// File: rtl/piradip_ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_CLIENTS requesters,
// with read data routed back after READ_LATENCY cycles.
// Optional bus locking is enabled by defining PIRADIP_RAM_ARB_LOCK_EN.
module piradip_ram_arbiter
  import piradip_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS  = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_CLIENTS-1:0]           req_valid,
  output logic [NUM_CLIENTS-1:0]           req_ready,
  input  logic [NUM_CLIENTS-1:0]           req_we,
`ifdef PIRADIP_RAM_ARB_LOCK_EN
  input  logic [NUM_CLIENTS-1:0]           req_lock,
`endif
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_CLIENTS-1:0]           rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             ram_en,
  output logic                             ram_we,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic [DATA_WIDTH-1:0]            ram_wdata,
  input  logic [DATA_WIDTH-1:0]            ram_rdata
);

  localparam int unsigned IDW = id_width(NUM_CLIENTS);

  arb_state_t           state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d, sel_ptr;
  logic [NUM_CLIENTS-1:0] eligible, grant;
  logic [IDW-1:0]       grant_idx;
  logic                 grant_any;
  pipe_entry_t          pipe_q [READ_LATENCY];

  function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] p);
    return (p == IDW'(NUM_CLIENTS - 1)) ? '0 : p + IDW'(1);
  endfunction

`ifdef PIRADIP_RAM_ARB_LOCK_EN
  logic [IDW-1:0] owner_q, owner_d;

  // While locked only the owner may compete.
  always_comb begin
    eligible = req_valid;
    sel_ptr  = rr_ptr_q;
    if (state_q == LOCKED) begin
      eligible = req_valid & (NUM_CLIENTS'(1) << owner_q);
      sel_ptr  = owner_q;
    end
  end
`else
  assign eligible = req_valid;
  assign sel_ptr  = rr_ptr_q;
`endif

  piradip_rr_select #(
    .N   (NUM_CLIENTS),
    .IDW (IDW)
  ) u_sel (
    .req   (eligible),
    .ptr   (sel_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign req_ready = grant;
  assign ram_en    = grant_any;
  assign rsp_rdata = ram_rdata;

  // Steer the winner's command onto the RAM port; zero when idle.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant_any) begin
      ram_we    = req_we[grant_idx];
      ram_addr  = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      ram_wdata = req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next state and round-robin pointer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
`ifdef PIRADIP_RAM_ARB_LOCK_EN
    owner_d  = owner_q;
`endif
    case (state_q)
      ARB: begin
        if (grant_any) begin
          rr_ptr_d = ptr_inc(grant_idx);
`ifdef PIRADIP_RAM_ARB_LOCK_EN
          if (req_lock[grant_idx]) begin
            state_d = LOCKED;
            owner_d = grant_idx;
          end
`endif
        end
      end
      LOCKED: begin
`ifdef PIRADIP_RAM_ARB_LOCK_EN
        if (grant_any && !req_lock[owner_q]) begin
          state_d  = ARB;
          rr_ptr_d = ptr_inc(owner_q);
        end
`else
        state_d = ARB;
`endif
      end
      default: state_d = ARB;
    endcase
  end

  // State, pointer and lock owner registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
`ifdef PIRADIP_RAM_ARB_LOCK_EN
      owner_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef PIRADIP_RAM_ARB_LOCK_EN
      owner_q  <= owner_d;
`endif
    end
  end

  // Read-return pipeline: tags each accepted read with its requester.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < int'(READ_LATENCY); k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= '{valid: grant_any & ~ram_we, id: MAX_ID_W'(grant_idx)};
      for (int k = 1; k < int'(READ_LATENCY); k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  // Decode the pipeline tail into the per-client response strobe.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
      rsp_valid[i] = pipe_q[READ_LATENCY-1].valid &&
                     (pipe_q[READ_LATENCY-1].id == MAX_ID_W'(i));
    end
  end

endmodule

// File: tb/tb_piradip_ram_arbiter.sv
// Bench for piradip_ram_arbiter: directed scenarios plus random traffic,
// checked every cycle against a queue/array reference model.
module tb_piradip_ram_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned RL = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, ram_rdata, ram_wdata;
  logic            ram_en, ram_we;
  logic [AW-1:0]   ram_addr;
  logic [AW-1:0]   caddr [N];
  logic [DW-1:0]   cdata [N];
`ifdef PIRADIP_RAM_ARB_LOCK_EN
  logic [N-1:0]    req_lock = '0;
`endif

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < int'(N); i++) begin
      req_addr[i*AW +: AW]  = caddr[i];
      req_wdata[i*DW +: DW] = cdata[i];
    end
  end

  piradip_ram_arbiter #(
    .NUM_CLIENTS  (N),
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (RL)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
`ifdef PIRADIP_RAM_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    return DW'(a) * 32'h0101_0101 ^ 32'hDEAD_0000;
  endfunction

  // RAM port model with RL-cycle read latency.
  logic [DW-1:0] ram_mem  [1024];
  logic [DW-1:0] ram_pipe [RL];
  assign ram_rdata = ram_pipe[RL-1];
  initial begin
    for (int a = 0; a < 1024; a++) ram_mem[a] = init_word(a);
    for (int k = 0; k < int'(RL); k++) ram_pipe[k] = '0;
    forever begin
      @(posedge clk);
      if (ram_en && ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr] : '0;
      for (int k = 1; k < int'(RL); k++) ram_pipe[k] <= ram_pipe[k-1];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pointer, memory image and scheduled responses.
  logic [N-1:0] macc;
  initial begin
    int           mptr, win, cyc, slot;
    logic [N-1:0] er;
    logic [N-1:0] sv [16];
    logic [DW-1:0] sd [16];
    logic [DW-1:0] mmem [1024];
    mptr = 0;
    cyc  = 0;
    macc = '0;
    for (int a = 0; a < 1024; a++) mmem[a] = init_word(a);
    for (int s = 0; s < 16; s++) begin sv[s] = '0; sd[s] = '0; end
    forever begin
      @(negedge clk);
      if (!rstn) begin
        mptr = 0;
        macc = '0;
        for (int s = 0; s < 16; s++) sv[s] = '0;
      end else begin
        win = -1;
        for (int k = 0; k < int'(N); k++)
          if (win < 0 && req_valid[(mptr + k) % N]) win = (mptr + k) % N;
        er = '0;
        if (win >= 0) er[win] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("ram_en", 64'(ram_en), 64'(win >= 0));
        if (win >= 0) begin
          chk("ram_we", 64'(ram_we), 64'(req_we[win]));
          chk("ram_addr", 64'(ram_addr), 64'(caddr[win]));
          if (req_we[win]) chk("ram_wdata", 64'(ram_wdata), 64'(cdata[win]));
        end else begin
          chk("idle_bus", {ram_we, ram_addr, ram_wdata}, 64'(0));
        end
        slot = cyc % 16;
        chk("rsp_valid", 64'(rsp_valid), 64'(sv[slot]));
        if (sv[slot] != '0) chk("rsp_rdata", 64'(rsp_rdata), 64'(sd[slot]));
        sv[slot] = '0;
        if (win >= 0) begin
          if (req_we[win]) mmem[caddr[win]] = cdata[win];
          else begin
            sv[(cyc + RL) % 16] = er;
            sd[(cyc + RL) % 16] = mmem[caddr[win]];
          end
          mptr = (win + 1) % N;
        end
        macc = er;
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit we, input int a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    caddr[i]     = AW'(a);
    cdata[i]     = d;
  endtask

  // From a drive point, wait (bounded) for client i to be accepted.
  task automatic wait_acc(input int i, input string nm);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready[i] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_accept"}, 64'(req_ready[i]), 64'(1));
  endtask

  int cnt [N];

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_we    = '0;
    for (int i = 0; i < int'(N); i++) begin caddr[i] = '0; cdata[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_ram_en", 64'(ram_en), 64'(0));
    step();
    rstn = 1'b1;

    // Client 2: two writes of 0xA5A5 to 0x10, then a read.
    set_req(2, 1'b1, 'h10, 32'hA5A5);
    wait_acc(2, "a_wr1");
    step();
    wait_acc(2, "a_wr2");
    step();
    set_req(2, 1'b0, 'h10, '0);
    wait_acc(2, "a_rd");
    step();
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("a_rsp_early", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    chk("a_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    chk("a_rsp_rdata", 64'(rsp_rdata), 64'(32'hA5A5));
    step();

    // Preload 5/9 from client 0, then back-to-back reads from clients 1 and 3.
    set_req(0, 1'b1, 5, 32'h55);
    wait_acc(0, "b_pre5");
    step();
    set_req(0, 1'b1, 9, 32'h99);
    wait_acc(0, "b_pre9");
    step();
    req_valid[0] = 1'b0;
    set_req(1, 1'b0, 5, '0);
    set_req(3, 1'b0, 9, '0);
    @(negedge clk);
    chk("b_grant1", 64'(req_ready), 64'(4'b0010));
    step();
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("b_grant3", 64'(req_ready), 64'(4'b1000));
    step();
    req_valid[3] = 1'b0;
    @(negedge clk);
    chk("b_rsp1_valid", 64'(rsp_valid), 64'(4'b0010));
    chk("b_rsp1_rdata", 64'(rsp_rdata), 64'(32'h55));
    @(negedge clk);
    chk("b_rsp3_valid", 64'(rsp_valid), 64'(4'b1000));
    chk("b_rsp3_rdata", 64'(rsp_rdata), 64'(32'h99));
    step();

    // Reset, then all four clients request continuously for 16 cycles.
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      set_req(i, 1'b1, 'h20 + i, DW'(i));
      cnt[i] = 0;
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("rr_order", 64'(req_ready), 64'(1) << (k % 4));
      for (int i = 0; i < int'(N); i++) if (req_ready[i]) cnt[i]++;
      step();
    end
    for (int i = 0; i < int'(N); i++) chk("rr_count", 64'(cnt[i]), 64'(4));
    req_valid = '0;
    step();

    // Read in flight when reset hits: its response must never appear.
    set_req(0, 1'b0, 5, '0);
    @(negedge clk);
    chk("r_grant0", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid[0] = 1'b0;
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("r_no_rsp", 64'(rsp_valid), 64'(0));
      step();
    end
    rstn = 1'b1;
    set_req(2, 1'b1, 'h30, 32'h1);
    set_req(3, 1'b1, 'h31, 32'h2);
    @(negedge clk);
    chk("r_first_grant", 64'(req_ready), 64'(4'b0100));
    chk("r_no_rsp_post", 64'(rsp_valid), 64'(0));
    step();
    req_valid[2] = 1'b0;
    wait_acc(3, "r_c3");
    step();
    req_valid[3] = 1'b0;

    // Idle: nothing granted and the pointer (now 0) is retained.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_ram_en", 64'(ram_en), 64'(0));
      chk("idle_ready", 64'(req_ready), 64'(0));
      step();
    end
    set_req(1, 1'b0, 'h30, '0);
    set_req(2, 1'b0, 'h31, '0);
    @(negedge clk);
    chk("idle_ptr_kept", 64'(req_ready), 64'(4'b0010));
    step();

    // Random traffic; clients hold requests until the model accepts them.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!req_valid[i] || macc[i]) begin
          if ($urandom_range(3, 0) != 0)
            set_req(i, 1'($urandom_range(1, 0)), int'($urandom_range(15, 0)), $urandom);
          else
            req_valid[i] = 1'b0;
        end
      end
      step();
    end
    req_valid = '0;
    repeat (RL + 3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
